// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared encodings for the multi-cycle controller: state codes,
//               opcodes, ALU operation codes and PC source select, plus small
//               opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

    // Controller state codes; the numeric values are visible on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd7
    } state_t;

    // Opcodes, instruction[31:26]
    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_SLL  = 6'b000001;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BGT  = 6'b000111;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_JR   = 6'b001001;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_SLT  = 6'b101010;
    localparam logic [5:0] OP_SW   = 6'b101011;

    // ALU operation codes
    localparam logic [3:0] ALU_PASS = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;

    // PC source select
    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_JR     = 2'b11;

    // True for every opcode the controller knows how to sequence.
    function automatic logic op_known(input logic [5:0] op);
        case (op)
            OP_NOP, OP_SLL, OP_J, OP_BGT, OP_ADDI, OP_JR, OP_ANDI, OP_ORI,
            OP_XORI, OP_ADD, OP_SUB, OP_LW, OP_AND, OP_OR, OP_XOR, OP_SLT,
            OP_SW:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Register-register ALU ops write rd; SLL is a shift on registers too.
    function automatic logic op_is_rtype(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLL: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    // Immediate-operand ALU ops.
    function automatic logic op_is_imm(input logic [5:0] op);
        case (op)
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    // ALU operation implied by an opcode; memory ops compute an address.
    function automatic logic [3:0] op_alu(input logic [5:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: return ALU_ADD;
            OP_SUB, OP_BGT:                return ALU_SUB;
            OP_AND, OP_ANDI:               return ALU_AND;
            OP_OR, OP_ORI:                 return ALU_OR;
            OP_XOR, OP_XORI:               return ALU_XOR;
            OP_SLT:                        return ALU_SLT;
            OP_SLL:                        return ALU_SLL;
            default:                       return ALU_PASS;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Bundle of IR/ALU/memory inputs and datapath control outputs
//               between the multi-cycle controller and the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             run;
    logic [5:0]       opcode;
    logic             alu_neg;
    logic             mem_ready;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [1:0]       pc_src;
    logic [3:0]       alu_op;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    // Controller side
    modport master (
        input  run, opcode, alu_neg, mem_ready,
        output ir_write, pc_write, reg_write, reg_dst, alu_src, mem_read,
               mem_write, mem_to_reg, pc_src, alu_op, state, illegal, retired
    );

    // Datapath side
    modport slave (
        output run, opcode, alu_neg, mem_ready,
        input  ir_write, pc_write, reg_write, reg_dst, alu_src, mem_read,
               mem_write, mem_to_reg, pc_src, alu_op, state, illegal, retired
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
// ============================================================================
// Module      : multicycle_ctrl_decode
// Description : Combinational next-state and strobe decode for the multi-cycle
//               controller (the mc_decode block). Strobes are decoded from the
//               current state and the latched opcode; DECODE looks at the live
//               IR opcode because op_q is only being loaded in that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] op_q,
    input  logic       run,
    input  logic       alu_neg,
    input  logic       mem_ready,
    output state_t     next_state,
    output logic       instr_done,
    output logic       op_load,
    output logic       illegal_set,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic [3:0] alu_op
);

    // Next state and per-state control strobes; everything defaults to idle.
    always_comb begin
        next_state  = state;
        instr_done  = 1'b0;
        op_load     = 1'b0;
        illegal_set = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        alu_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        pc_src      = PC_NEXT;
        alu_op      = ALU_PASS;

        case (state)
            ST_IDLE: begin
                if (run) begin
                    next_state = ST_FETCH;
                end
            end

            ST_FETCH: begin
                ir_write   = 1'b1;
                next_state = ST_DECODE;
            end

            ST_DECODE: begin
                op_load = 1'b1;
                case (opcode)
                    OP_NOP: begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_J: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_JUMP;
                        instr_done = 1'b1;
                    end
                    OP_JR: begin
                        pc_write   = 1'b1;
                        pc_src     = PC_JR;
                        instr_done = 1'b1;
                    end
                    default: begin
                        if (op_known(opcode)) begin
                            next_state = ST_EXEC;
                        end else begin
                            illegal_set = 1'b1;
                            next_state  = ST_HALT;
                        end
                    end
                endcase
            end

            ST_EXEC: begin
                alu_op  = op_alu(op_q);
                alu_src = op_is_imm(op_q) || (op_q == OP_LW) || (op_q == OP_SW);
                if (op_q == OP_BGT) begin
                    pc_write   = 1'b1;
                    pc_src     = alu_neg ? PC_BRANCH : PC_NEXT;
                    instr_done = 1'b1;
                end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    next_state = ST_MEM;
                end else begin
                    next_state = ST_WB;
                end
            end

            ST_MEM: begin
                // Address stays on the ALU for the whole access.
                alu_op    = ALU_ADD;
                alu_src   = 1'b1;
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q == OP_SW);
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        next_state = ST_WB;
                    end else begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                    end
                end
            end

            ST_WB: begin
                alu_op     = op_alu(op_q);
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                reg_dst    = op_is_rtype(op_q);
                mem_to_reg = (op_q == OP_LW);
                instr_done = 1'b1;
            end

            ST_HALT: begin
                next_state = ST_HALT;
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // Every completed instruction either chains into the next fetch or parks.
        if (instr_done) begin
            next_state = run ? ST_FETCH : ST_IDLE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle control FSM. Holds the state register, latched
//               opcode, sticky illegal flag and retired-instruction counter;
//               strobe decode lives in multicycle_ctrl_decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [5:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic             instr_done;
    logic             op_load;
    logic             illegal_set;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [1:0]       pc_src;
    logic [3:0]       alu_op;

    multicycle_ctrl_decode u_decode (
        .state       (state_q),
        .opcode      (bus.opcode),
        .op_q        (op_q),
        .run         (bus.run),
        .alu_neg     (bus.alu_neg),
        .mem_ready   (bus.mem_ready),
        .next_state  (state_d),
        .instr_done  (instr_done),
        .op_load     (op_load),
        .illegal_set (illegal_set),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .pc_src      (pc_src),
        .alu_op      (alu_op)
    );

    // State register, opcode latch, sticky illegal flag and retire counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (op_load) begin
                op_q <= bus.opcode;
            end
            if (illegal_set) begin
                illegal_q <= 1'b1;
            end
            if (instr_done) begin
                retired_q <= retired_q + CNT_ONE;
            end
        end
    end

    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.alu_src    = alu_src;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.pc_src     = pc_src;
    assign bus.alu_op     = alu_op;
    assign bus.state      = state_q;
    assign bus.illegal    = illegal_q;
    assign bus.retired    = retired_q;

endmodule

`default_nettype wire
